// File: rtl/resnet_conv.sv
// Streaming 3x3 single-channel convolution: nine-word kernel load, raster image stream.
// Optional ReLU output stage when RESNET_RELU_EN is defined.
module resnet_conv #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en,
    input  logic [DATA_W-1:0] hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read
                                  [0:0],
    output logic              hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
    input  logic [DATA_W-1:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read
                                  [0:0],
    output logic              hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
    output logic [DATA_W-1:0] hw_output_stencil_op_hcompute_hw_output_stencil_write [0:0]
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {StIdle, StLoadK, StStream, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DATA_W-1:0] w_q   [9];
    logic [DATA_W-1:0] w_d   [9];
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb0_d [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb1_d [IMG_W];
    logic              pend_q, pend_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] acc, res;
    logic [DATA_W-1:0] kword, pixel;

    assign kword = hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read[0];
    assign pixel = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read[0];

    assign hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en =
        (state_q == StLoadK);
    assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en =
        (state_q == StStream);
    assign hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = vld_q;
    assign hw_output_stencil_op_hcompute_hw_output_stencil_write[0]    = dat_q;

    // Window holds the pixel captured on the previous edge; products wrap modulo 2^DATA_W.
    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + w_q[i] * win_q[i];
        end
`ifdef RESNET_RELU_EN
        res = acc[DATA_W-1] ? '0 : acc;
`else
        res = acc;
`endif
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        win_d   = win_q;
        lb0_d   = lb0_q;
        lb1_d   = lb1_q;
        pend_d  = 1'b0;
        vld_d   = pend_q;
        dat_d   = pend_q ? res : dat_q;

        unique case (state_q)
            StLoadK: begin
                w_d[k_q] = kword;
                if (k_q == 4'd8) begin
                    k_d     = '0;
                    state_d = StStream;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StStream: begin
                // Column entering the window: two rows up, one row up, current pixel.
                for (int r = 0; r < 3; r++) begin
                    win_d[3*r]   = win_q[3*r+1];
                    win_d[3*r+1] = win_q[3*r+2];
                end
                win_d[2]   = lb1_q[x_q];
                win_d[5]   = lb0_q[x_q];
                win_d[8]   = pixel;
                lb1_d[x_q] = lb0_q[x_q];
                lb0_d[x_q] = pixel;
                pend_d     = (x_q >= XW'(2)) && (y_q >= YW'(2));
                if (x_q == XW'(IMG_W - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(IMG_H - 1)) begin
                        y_d     = '0;
                        state_d = StDone;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            default: ;
        endcase

        if (flush) begin
            state_d = StLoadK;
            k_d     = '0;
            x_d     = '0;
            y_d     = '0;
            win_d   = '{default: '0};
            lb0_d   = '{default: '0};
            lb1_d   = '{default: '0};
            pend_d  = 1'b0;
            vld_d   = 1'b0;
            dat_d   = dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '{default: '0};
            win_q   <= '{default: '0};
            lb0_q   <= '{default: '0};
            lb1_q   <= '{default: '0};
            pend_q  <= 1'b0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            win_q   <= win_d;
            lb0_q   <= lb0_d;
            lb1_q   <= lb1_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_resnet_conv.sv
// Directed bench for resnet_conv: reset, frame timing, convolution values, abort and reset.
module tb_resnet_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        k_en, i_en, vld;
    logic [15:0] kdata [0:0];
    logic [15:0] idata [0:0];
    logic [15:0] odata [0:0];

    int passed = 0;
    int total  = 0;
    int kidx   = 0;
    int pidx   = 0;
    bit ones   = 1'b0;

    logic        ken_a [0:199];
    logic        ien_a [0:199];
    logic        vld_a [0:199];
    logic [15:0] dat_a [0:199];
    logic [15:0] res [$];
    int k_first, k_cnt, i_first, i_cnt, v_first, v_last;

    always #5 clk = ~clk;

    resnet_conv dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en (k_en),
        .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read    (kdata),
        .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en   (i_en),
        .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read      (idata),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid            (vld),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write                  (odata)
    );

    // Stream sources: present data combinationally, advance after an edge with read_en high.
    assign kdata[0] = ones ? 16'hFFFF : 16'(kidx);
    assign idata[0] = ones ? 16'h0001 : 16'(pidx);

    always @(posedge clk) begin
        if (rst || flush) begin
            kidx <= 0;
            pidx <= 0;
        end else begin
            if (k_en) kidx <= kidx + 1;
            if (i_en) pidx <= pidx + 1;
        end
    end

    // Counter-pattern expectation: kernel 0..8, pixel 8y+x.
    function automatic logic [15:0] exp_val(input int n);
        int y, x;
        y = n / 6 + 2;
        x = n % 6 + 2;
        return 16'(36 * (8 * y + x - 18) + 474);
    endfunction

    task automatic pulse_flush();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic record(input int n);
        res.delete();
        k_first = -1; k_cnt = 0; i_first = -1; i_cnt = 0; v_first = -1; v_last = -1;
        for (int c = 0; c < n; c++) begin
            ken_a[c] = k_en;
            ien_a[c] = i_en;
            vld_a[c] = vld;
            dat_a[c] = odata[0];
            if (k_en) begin
                if (k_first < 0) k_first = c;
                k_cnt++;
            end
            if (i_en) begin
                if (i_first < 0) i_first = c;
                i_cnt++;
            end
            if (vld) begin
                if (v_first < 0) v_first = c;
                v_last = c;
                res.push_back(odata[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({k_en, i_en, vld} !== 3'b000 || odata[0] !== 16'h0000) begin
            $display("FAIL reset_outputs: got ken=%b ien=%b vld=%b data=%h, want all 0",
                     k_en, i_en, vld, odata[0]);
        end else passed++;
        rst = 1'b0;
        act = 0;
        repeat (15) begin
            @(negedge clk);
            if (k_en || i_en || vld) act++;
        end
        total++;
        if (act !== 0) $display("FAIL idle_hold: got %0d active cycles, want 0", act);
        else passed++;
    endtask

    task automatic test_frame_timing();
        int bad;
        ones = 1'b0;
        pulse_flush();
        record(80);
        total++;
        if (k_first !== 0 || k_cnt !== 9)
            $display("FAIL kernel_window: got first=%0d count=%0d, want 0/9", k_first, k_cnt);
        else passed++;
        total++;
        if (i_first !== 9 || i_cnt !== 64)
            $display("FAIL input_window: got first=%0d count=%0d, want 9/64", i_first, i_cnt);
        else passed++;
        total++;
        if (ken_a[79] !== 1'b0 || ien_a[79] !== 1'b0)
            $display("FAIL done_idle: got ken=%b ien=%b, want 0/0", ken_a[79], ien_a[79]);
        else passed++;
        total++;
        if (v_first !== 29 || v_last !== 74)
            $display("FAIL valid_span: got %0d..%0d, want 29..74", v_first, v_last);
        else passed++;
        total++;
        if (res.size() !== 36) $display("FAIL result_count: got %0d, want 36", res.size());
        else passed++;
        if (res.size() == 36) begin
            total++;
            if (res[0] !== 16'd474) $display("FAIL first_result: got %0d, want 474", res[0]);
            else passed++;
            total++;
            if (res[1] !== 16'd510) $display("FAIL second_result: got %0d, want 510", res[1]);
            else passed++;
            total++;
            if (res[6] !== 16'd762) $display("FAIL seventh_result: got %0d, want 762", res[6]);
            else passed++;
            total++;
            if (res[35] !== 16'd2094) $display("FAIL last_result: got %0d, want 2094", res[35]);
            else passed++;
            bad = 0;
            for (int n = 0; n < 36; n++) if (res[n] !== exp_val(n)) bad++;
            total++;
            if (bad !== 0) $display("FAIL all_results: got %0d wrong, want 0", bad);
            else passed++;
        end
        total++;
        if (vld_a[35] !== 1'b0 || dat_a[35] !== 16'd654)
            $display("FAIL data_hold: got vld=%b data=%0d, want 0/654", vld_a[35], dat_a[35]);
        else passed++;
    endtask

    task automatic test_all_ones();
        logic [15:0] want;
        int bad;
`ifdef RESNET_RELU_EN
        want = 16'h0000;
`else
        want = 16'hFFF7;
`endif
        ones = 1'b1;
        pulse_flush();
        record(80);
        ones = 1'b0;
        bad = 0;
        foreach (res[n]) if (res[n] !== want) bad++;
        total++;
        if (res.size() !== 36 || bad !== 0)
            $display("FAIL all_ones: got count=%0d wrong=%0d, want 36 of %h",
                     res.size(), bad, want);
        else passed++;
    endtask

    task automatic test_abort();
        int seen_i, seen_v, bad;
        ones = 1'b0;
        pulse_flush();
        seen_i = 0;
        seen_v = 0;
        for (int c = 0; c < 29; c++) begin
            if (i_en) seen_i++;
            if (vld) seen_v++;
            if (c < 28) @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        total++;
        if (seen_i !== 20 || seen_v !== 0)
            $display("FAIL abort_prefix: got pixels=%0d results=%0d, want 20/0", seen_i, seen_v);
        else passed++;
        record(80);
        total++;
        if (k_first !== 0 || k_cnt !== 9 || i_cnt !== 64 || v_first !== 29)
            $display("FAIL abort_restart: got kfirst=%0d kcnt=%0d icnt=%0d vfirst=%0d, want 0/9/64/29",
                     k_first, k_cnt, i_cnt, v_first);
        else passed++;
        bad = 0;
        for (int n = 0; n < res.size(); n++) if (res[n] !== exp_val(n)) bad++;
        total++;
        if (res.size() !== 36 || bad !== 0)
            $display("FAIL abort_results: got count=%0d wrong=%0d, want 36/0", res.size(), bad);
        else passed++;
    endtask

    task automatic test_rst_mid_stream();
        int act;
        pulse_flush();
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({k_en, i_en, vld} !== 3'b000)
            $display("FAIL rst_mid: got ken=%b ien=%b vld=%b, want 000", k_en, i_en, vld);
        else passed++;
        rst = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (k_en || i_en || vld) act++;
        end
        total++;
        if (act !== 0) $display("FAIL rst_idle: got %0d active cycles, want 0", act);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_all_ones();
        test_abort();
        test_rst_mid_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
